// File: rtl/axi_slave_package.sv
// Shared AXI write-path types and width constants for the AW/W FIFO popping logic.
package axi_slave_package;

  localparam int AXI_ID_W   = 4;
  localparam int AXI_ADDR_W = 64;
  localparam int AXI_DATA_W = 1024;
  localparam int AXI_STRB_W = AXI_DATA_W / 8;
  localparam int AXI_USER_W = 8;

  localparam logic [1:0] BURST_INCR = 2'b01;

  typedef enum logic [1:0] {
    POP_IDLE,
    POP_HDR,
    POP_DATA
  } pop_state_e;

  typedef struct packed {
    logic [AXI_ID_W-1:0]   awid;
    logic [AXI_ADDR_W-1:0] awaddr;
    logic [7:0]            awlen;
    logic [2:0]            awsize;
    logic [1:0]            awburst;
    logic [AXI_USER_W-1:0] awuser;
  } aw_entry_t;

  typedef struct packed {
    logic [AXI_ID_W-1:0]   wid;
    logic [AXI_DATA_W-1:0] wdata;
    logic [AXI_STRB_W-1:0] wstrb;
    logic                  wlast;
  } w_entry_t;

endpackage

// File: rtl/axi_pop_fsm_wr.sv
// Pops one AW entry, presents it as a header, then streams exactly AWLEN+1 W beats
// to the TLP formatter; beat termination is counted, WLAST is only cross-checked.
module axi_pop_fsm_wr
  import axi_slave_package::*;
#(
  parameter int ID_W   = AXI_ID_W,
  parameter int ADDR_W = AXI_ADDR_W,
  parameter int DATA_W = AXI_DATA_W,
  parameter int USER_W = AXI_USER_W,
  parameter int STRB_W = DATA_W / 8
) (
  input  logic              axi_clk,
  input  logic              ARESTn,
  input  logic              AWFIFO_empty,
  input  aw_entry_t         AWFIFO_rd_data,
  output logic              AWFIFO_rd_en,
  input  logic              WFIFO_empty,
  input  w_entry_t          WFIFO_rd_data,
  output logic              WFIFO_rd_en,
  output logic              hdr_valid,
  input  logic              hdr_ready,
  output logic [ID_W-1:0]   hdr_id,
  output logic [ADDR_W-1:0] hdr_addr,
  output logic [7:0]        hdr_len,
  output logic [2:0]        hdr_size,
  output logic [1:0]        hdr_burst,
  output logic [USER_W-1:0] hdr_user,
  output logic              dat_valid,
  input  logic              dat_ready,
  output logic [DATA_W-1:0] dat_data,
  output logic [STRB_W-1:0] dat_strb,
  output logic              dat_last,
  output logic              wlast_err
);

  pop_state_e        r_state;
  logic [8:0]        r_cnt;
  logic [ID_W-1:0]   r_hdr_id;
  logic [ADDR_W-1:0] r_hdr_addr;
  logic [7:0]        r_hdr_len;
  logic [2:0]        r_hdr_size;
  logic [1:0]        r_hdr_burst;
  logic [USER_W-1:0] r_hdr_user;
  logic              r_wlast_err;

  logic w_in_data;
  logic w_cnt_zero;
  logic w_dat_xfer;
  logic w_unused;

  // Burst sequencer: header capture, remaining-beat counter and WLAST cross-check.
  always_ff @(posedge axi_clk or negedge ARESTn) begin
    if (!ARESTn) begin
      r_state     <= POP_IDLE;
      r_cnt       <= '0;
      r_hdr_id    <= '0;
      r_hdr_addr  <= '0;
      r_hdr_len   <= '0;
      r_hdr_size  <= '0;
      r_hdr_burst <= '0;
      r_hdr_user  <= '0;
      r_wlast_err <= 1'b0;
    end else begin
      r_wlast_err <= 1'b0;
      case (r_state)
        POP_IDLE: begin
          if (!AWFIFO_empty) begin
            r_hdr_id    <= AWFIFO_rd_data.awid;
            r_hdr_addr  <= AWFIFO_rd_data.awaddr;
            r_hdr_len   <= AWFIFO_rd_data.awlen;
            r_hdr_size  <= AWFIFO_rd_data.awsize;
            r_hdr_burst <= AWFIFO_rd_data.awburst;
            r_hdr_user  <= AWFIFO_rd_data.awuser;
            r_cnt       <= {1'b0, AWFIFO_rd_data.awlen};
            r_state     <= POP_HDR;
          end
        end
        POP_HDR: begin
          if (hdr_ready) begin
            r_state <= POP_DATA;
          end
        end
        POP_DATA: begin
          if (w_dat_xfer) begin
            r_wlast_err <= (WFIFO_rd_data.wlast != w_cnt_zero);
            if (w_cnt_zero) begin
              r_state <= POP_IDLE;
            end else begin
              r_cnt <= r_cnt - 9'd1;
            end
          end
        end
        default: r_state <= POP_IDLE;
      endcase
    end
  end

  // The AW pop is gated by ARESTn so nothing is consumed while reset is held.
  always_comb begin
    w_in_data    = (r_state == POP_DATA);
    w_cnt_zero   = (r_cnt == 9'd0);
    AWFIFO_rd_en = ARESTn && (r_state == POP_IDLE) && !AWFIFO_empty;
    hdr_valid    = (r_state == POP_HDR);
    hdr_id       = r_hdr_id;
    hdr_addr     = r_hdr_addr;
    hdr_len      = r_hdr_len;
    hdr_size     = r_hdr_size;
    hdr_burst    = r_hdr_burst;
    hdr_user     = r_hdr_user;
    dat_valid    = w_in_data && !WFIFO_empty;
    dat_data     = w_in_data ? WFIFO_rd_data.wdata : '0;
    dat_strb     = w_in_data ? WFIFO_rd_data.wstrb : '0;
    dat_last     = w_in_data && w_cnt_zero;
    w_dat_xfer   = dat_valid && dat_ready;
    WFIFO_rd_en  = w_dat_xfer;
    wlast_err    = r_wlast_err;
    w_unused     = ^WFIFO_rd_data.wid;
  end

endmodule

// File: tb/tb_axi_pop_fsm_wr.sv
// Directed bench for axi_pop_fsm_wr: queue-backed AW/W FIFO models, a monitor that logs
// every pop, and immediate assertions against hand-computed expectations.
module tb_axi_pop_fsm_wr;
  import axi_slave_package::*;

  logic              axi_clk;
  logic              ARESTn;
  logic              AWFIFO_empty;
  aw_entry_t         AWFIFO_rd_data;
  logic              AWFIFO_rd_en;
  logic              WFIFO_empty;
  w_entry_t          WFIFO_rd_data;
  logic              WFIFO_rd_en;
  logic              hdr_valid;
  logic              hdrReady;
  logic [3:0]        hdr_id;
  logic [63:0]       hdr_addr;
  logic [7:0]        hdr_len;
  logic [2:0]        hdr_size;
  logic [1:0]        hdr_burst;
  logic [7:0]        hdr_user;
  logic              dat_valid;
  logic              datReady;
  logic [1023:0]     dat_data;
  logic [127:0]      dat_strb;
  logic              dat_last;
  logic              wlast_err;

  aw_entry_t   awQ[$];
  w_entry_t    wQ[$];
  logic        wHold;

  int          numCompared;
  int          numMismatched;
  int          cyc;
  int          awPops;
  int          wPops;
  int          hdrCycles;
  int          lastCount;
  int          errPulses;
  int          overlap;
  int          awPopCyc[$];
  int          lastCyc[$];
  logic [31:0] beatTag[$];
  logic [7:0]  beatStrb[$];
  logic        beatLast[$];
  logic        monDoAw;
  logic        monDoW;
  int          lastIdx;
  int          gap;

  axi_pop_fsm_wr dut (
    .axi_clk        (axi_clk),
    .ARESTn         (ARESTn),
    .AWFIFO_empty   (AWFIFO_empty),
    .AWFIFO_rd_data (AWFIFO_rd_data),
    .AWFIFO_rd_en   (AWFIFO_rd_en),
    .WFIFO_empty    (WFIFO_empty),
    .WFIFO_rd_data  (WFIFO_rd_data),
    .WFIFO_rd_en    (WFIFO_rd_en),
    .hdr_valid      (hdr_valid),
    .hdr_ready      (hdrReady),
    .hdr_id         (hdr_id),
    .hdr_addr       (hdr_addr),
    .hdr_len        (hdr_len),
    .hdr_size       (hdr_size),
    .hdr_burst      (hdr_burst),
    .hdr_user       (hdr_user),
    .dat_valid      (dat_valid),
    .dat_ready      (datReady),
    .dat_data       (dat_data),
    .dat_strb       (dat_strb),
    .dat_last       (dat_last),
    .wlast_err      (wlast_err)
  );

  initial axi_clk = 1'b0;
  always #5 axi_clk = ~axi_clk;

  function automatic void refreshFifo();
    AWFIFO_empty   = (awQ.size() == 0);
    AWFIFO_rd_data = (awQ.size() != 0) ? awQ[0] : '0;
    WFIFO_empty    = (wQ.size() == 0) || wHold;
    WFIFO_rd_data  = (wQ.size() != 0) ? wQ[0] : '0;
  endfunction

  function automatic void clearCounters();
    awPops = 0; wPops = 0; hdrCycles = 0; lastCount = 0; errPulses = 0;
    awPopCyc.delete(); lastCyc.delete();
    beatTag.delete(); beatStrb.delete(); beatLast.delete();
  endfunction

  // Monitor: sample handshakes just before the edge takes effect, then pop the FIFO models.
  always @(posedge axi_clk) begin
    cyc++;
    monDoAw = AWFIFO_rd_en;
    monDoW  = WFIFO_rd_en;
    if (hdr_valid) hdrCycles++;
    if (hdr_valid && dat_valid) overlap++;
    if (wlast_err) errPulses++;
    if (monDoAw) begin
      awPops++;
      awPopCyc.push_back(cyc);
    end
    if (monDoW) begin
      wPops++;
      beatTag.push_back(dat_data[31:0]);
      beatStrb.push_back(dat_strb[7:0]);
      beatLast.push_back(dat_last);
      if (dat_last) begin
        lastCount++;
        lastCyc.push_back(cyc);
      end
    end
    #1;
    if (monDoAw && awQ.size() != 0) void'(awQ.pop_front());
    if (monDoW && wQ.size() != 0) void'(wQ.pop_front());
    refreshFifo();
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    numCompared++;
    assert (observed === expected) else begin
      numMismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge axi_clk);
    #2;
  endtask

  task automatic pushW(input int tag, input logic last);
    w_entry_t w;
    logic [31:0] t;
    t = tag;
    w.wid   = 4'h0;
    w.wdata = {32{t}};
    w.wstrb = {16{t[7:0]}};
    w.wlast = last;
    wQ.push_back(w);
  endtask

  task automatic applyStimulus(input logic [3:0] id, input logic [63:0] addr, input logic [7:0] len,
                               input logic [1:0] burst, input int tagBase, input int nBeats,
                               input int extraLast);
    aw_entry_t aw;
    aw.awid    = id;
    aw.awaddr  = addr;
    aw.awlen   = len;
    aw.awsize  = 3'd7;
    aw.awburst = burst;
    aw.awuser  = 8'hA5;
    awQ.push_back(aw);
    for (int i = 0; i < nBeats; i++) begin
      pushW(tagBase + i, (i == int'(len)) || (i == extraLast));
    end
    refreshFifo();
  endtask

  task automatic waitDone(input int target, input int budget, input string tag);
    int n;
    n = 0;
    while (lastCount < target && n < budget) begin
      tick();
      n++;
    end
    checkOutput(tag, lastCount, target);
  endtask

  initial begin
    numCompared = 0; numMismatched = 0; cyc = 0; overlap = 0;
    ARESTn = 1'b0; hdrReady = 1'b1; datReady = 1'b1; wHold = 1'b0;
    clearCounters();
    refreshFifo();

    // Single-beat burst; entry already waiting while reset is held.
    applyStimulus(4'h3, 64'h1000_0000_0000_0040, 8'd0, BURST_INCR, 'h100, 1, -1);
    #12;
    checkOutput("rst_aw_rd_en", AWFIFO_rd_en, 0);
    checkOutput("rst_hdr_valid", hdr_valid, 0);
    checkOutput("rst_dat_valid", dat_valid, 0);
    checkOutput("rst_w_rd_en", WFIFO_rd_en, 0);
    checkOutput("rst_wlast_err", wlast_err, 0);
    checkOutput("rst_hdr_addr", hdr_addr, 0);
    tick(); tick();
    checkOutput("rst_no_pop", awPops, 0);
    clearCounters();
    @(negedge axi_clk);
    ARESTn = 1'b1;
    waitDone(1, 20, "t1_done");
    tick(); tick();
    checkOutput("t1_aw_pops", awPops, 1);
    checkOutput("t1_hdr_cycles", hdrCycles, 1);
    checkOutput("t1_w_pops", wPops, 1);
    checkOutput("t1_beat_tag", beatTag[0], 'h100);
    checkOutput("t1_beat_strb", beatStrb[0], 8'h00);
    checkOutput("t1_beat_last", beatLast[0], 1);
    checkOutput("t1_wlast_err", errPulses, 0);
    checkOutput("t1_hdr_addr", hdr_addr, 64'h1000_0000_0000_0040);
    checkOutput("t1_hdr_id", hdr_id, 4'h3);
    checkOutput("t1_hdr_size", hdr_size, 3'd7);
    checkOutput("t1_hdr_user", hdr_user, 8'hA5);

    // Maximum-length burst.
    clearCounters();
    applyStimulus(4'h1, 64'h2000, 8'd255, BURST_INCR, 0, 256, -1);
    waitDone(1, 400, "t2_done");
    tick();
    lastIdx = -1;
    for (int i = 0; i < beatLast.size(); i++) begin
      if (beatLast[i] && lastIdx < 0) lastIdx = i;
    end
    checkOutput("t2_w_pops", wPops, 256);
    checkOutput("t2_last_count", lastCount, 1);
    checkOutput("t2_last_idx", lastIdx, 255);
    checkOutput("t2_first_tag", beatTag[0], 0);
    checkOutput("t2_final_tag", beatTag[255], 255);
    checkOutput("t2_hdr_len", hdr_len, 8'd255);
    checkOutput("t2_wlast_err", errPulses, 0);

    // Header back-pressure, toggling dat_ready and a W FIFO underrun mid-burst.
    clearCounters();
    hdrReady = 1'b0; datReady = 1'b0;
    applyStimulus(4'h7, 64'h3000_0100, 8'd3, BURST_INCR, 'h20, 4, -1);
    tick();
    repeat (5) tick();
    checkOutput("t3_hdr_valid_held", hdr_valid, 1);
    checkOutput("t3_hdr_addr_held", hdr_addr, 64'h3000_0100);
    checkOutput("t3_hdr_len_held", hdr_len, 8'd3);
    checkOutput("t3_no_w_in_hdr", wPops, 0);
    hdrReady = 1'b1;
    tick();
    for (int n = 0; n < 20 && wPops < 2; n++) begin
      datReady = ~datReady;
      tick();
    end
    checkOutput("t3_two_beats", wPops, 2);
    wHold = 1'b1; datReady = 1'b1;
    refreshFifo();
    tick(); tick();
    checkOutput("t3_stall_pops", wPops, 2);
    checkOutput("t3_stall_valid", dat_valid, 0);
    wHold = 1'b0;
    refreshFifo();
    for (int n = 0; n < 20 && lastCount < 1; n++) begin
      datReady = ~datReady;
      tick();
    end
    checkOutput("t3_done", lastCount, 1);
    datReady = 1'b1;
    tick();
    checkOutput("t3_w_pops", wPops, 4);
    for (int i = 0; i < 4; i++) checkOutput($sformatf("t3_order_%0d", i), beatTag[i], 'h20 + i);
    checkOutput("t3_last_on_4", beatLast[3], 1);

    // Early WLAST on beat 2.
    clearCounters();
    applyStimulus(4'h2, 64'h4000, 8'd3, BURST_INCR, 'h40, 4, 1);
    waitDone(1, 30, "t4_done");
    tick(); tick();
    checkOutput("t4_err_pulses", errPulses, 1);
    checkOutput("t4_w_pops", wPops, 4);
    checkOutput("t4_last_count", lastCount, 1);
    checkOutput("t4_last_on_4", beatLast[3], 1);
    checkOutput("t4_beat2_not_last", beatLast[1], 0);

    // Back-to-back bursts; second carries a WRAP burst type.
    clearCounters();
    applyStimulus(4'h4, 64'h5000, 8'd1, BURST_INCR, 'h60, 2, -1);
    applyStimulus(4'h5, 64'h6000, 8'd1, 2'b10, 'h70, 2, -1);
    waitDone(2, 40, "t5_done");
    tick(); tick();
    gap = (awPopCyc.size() == 2 && lastCyc.size() == 2) ? awPopCyc[1] - lastCyc[0] : -1;
    checkOutput("t5_aw_pops", awPops, 2);
    checkOutput("t5_w_pops", wPops, 4);
    checkOutput("t5_aw_gap", gap, 1);
    checkOutput("t5_hdr_burst", hdr_burst, 2'b10);
    checkOutput("t5_hdr_id", hdr_id, 4'h5);
    checkOutput("t5_hdr_addr", hdr_addr, 64'h6000);

    // Reset during beat 2 of an 8-beat burst, with the next AW entry already queued.
    clearCounters();
    applyStimulus(4'h1, 64'h7000, 8'd7, BURST_INCR, 'h80, 8, -1);
    applyStimulus(4'h2, 64'h8000, 8'd0, BURST_INCR, 'h90, 0, -1);
    for (int n = 0; n < 20 && wPops < 1; n++) tick();
    checkOutput("t6_beat1_done", wPops, 1);
    checkOutput("t6_aw_held", awPops, 1);
    ARESTn = 1'b0;
    #1;
    checkOutput("t6_rst_hdr_valid", hdr_valid, 0);
    checkOutput("t6_rst_dat_valid", dat_valid, 0);
    checkOutput("t6_rst_w_rd_en", WFIFO_rd_en, 0);
    checkOutput("t6_rst_aw_rd_en", AWFIFO_rd_en, 0);
    checkOutput("t6_rst_dat_last", dat_last, 0);
    checkOutput("t6_rst_hdr_addr", hdr_addr, 0);
    checkOutput("t6_rst_hdr_len", hdr_len, 0);
    checkOutput("t6_rst_wlast_err", wlast_err, 0);
    wQ.delete();
    pushW('h91, 1'b1);
    refreshFifo();
    tick();
    clearCounters();
    @(negedge axi_clk);
    ARESTn = 1'b1;
    waitDone(1, 20, "t6_done");
    tick(); tick();
    checkOutput("t6_aw_pops", awPops, 1);
    checkOutput("t6_w_pops", wPops, 1);
    checkOutput("t6_hdr_addr", hdr_addr, 64'h8000);
    checkOutput("t6_hdr_id", hdr_id, 4'h2);
    checkOutput("t6_beat_tag", beatTag[0], 'h91);
    checkOutput("t6_wlast_err", errPulses, 0);

    checkOutput("hdr_dat_overlap", overlap, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
    $finish;
  end

endmodule
